// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the pattern run controller: FSM state codes
// (also driven onto the LED/debug state output) and prescaler defaults.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // 1 Hz shift strobe from a 12 MHz system clock
    localparam int unsigned DEF_DIV_W   = 24;
    localparam int unsigned DEF_DIV_MAX = 11_999_999;

endpackage

// File: rtl/seq_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV_MAX+1 enabled cycles.
// clr forces the count to zero and blocks the tick; hold freezes the count
// and blocks the tick, so a held terminal count fires as soon as hold drops.
module seq_tick_gen
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W   = DEF_DIV_W,
    parameter int unsigned DIV_MAX = DEF_DIV_MAX
) (
    input  logic sysclk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(DIV_MAX);

    logic [DIV_W-1:0] cnt;

    // Prescaler count: clear, hold, or advance with wrap at terminal count
    always_ff @(posedge sysclk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!hold) begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

    assign tick = !clr && !hold && (cnt == CNT_MAX);

endmodule

// File: rtl/seq_run_ctrl.sv
// Run controller for the serial pattern shifter. Loads the pattern, issues
// shift strobes from the prescaler, counts bits and passes, and handles
// pause/stop. All outputs are registered.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for start; counters hold results of the last run
//  S_LOAD  | one cycle, ld high; config latched and counters zeroed
//  S_RUN   | prescaler running, shift strobes advance bit/pass counters
//  S_PAUSE | pause high: prescaler and counters frozen
//  S_DONE  | one cycle, done high; final pass reached
module seq_run_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W   = DEF_DIV_W,
    parameter int unsigned DIV_MAX = DEF_DIV_MAX,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned REP_W   = 8
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [LEN_W-1:0] pat_len,
    input  logic [REP_W-1:0] rep_num,
    output logic             ld,
    output logic             sh_en,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] bit_idx,
    output logic [REP_W-1:0] pass_cnt,
    output logic [2:0]       state_o
);

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] len_q;
    logic [REP_W-1:0] rep_q;
    logic             run_act;
    logic             tick_clr;
    logic             tick;
    logic             launch;

    // Prescaler only runs in RUN/PAUSE; a stop clears it and kills any strobe.
    // Pause gates it in both states, so a coincident terminal count is held.
    assign run_act  = (state == S_RUN) || (state == S_PAUSE);
    assign tick_clr = !run_act || stop;
    assign launch   = (state == S_IDLE) && (state_nx == S_LOAD);

    seq_tick_gen #(
        .DIV_W   (DIV_W),
        .DIV_MAX (DIV_MAX)
    ) u_tick (
        .sysclk (sysclk),
        .rst    (rst),
        .clr    (tick_clr),
        .hold   (pause),
        .tick   (tick)
    );

    // Next-state decode; stop outranks completion, completion outranks pause
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start && !stop) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (stop)       state_nx = S_IDLE;
                else if (pause) state_nx = S_PAUSE;
                else            state_nx = S_RUN;
            end
            S_RUN, S_PAUSE: begin
                if (stop)                                 state_nx = S_IDLE;
                else if (rep_q != '0 && pass_cnt == rep_q) state_nx = S_DONE;
                else if (pause)                           state_nx = S_PAUSE;
                else                                      state_nx = S_RUN;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge sysclk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered strobes, config latch, and bit/pass counters
    always_ff @(posedge sysclk) begin
        if (!rst) begin
            ld       <= 1'b0;
            sh_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            len_q    <= '0;
            rep_q    <= '0;
            bit_idx  <= '0;
            pass_cnt <= '0;
        end else begin
            ld    <= (state_nx == S_LOAD);
            done  <= (state_nx == S_DONE);
            busy  <= (state_nx == S_LOAD) || (state_nx == S_RUN) || (state_nx == S_PAUSE);
            sh_en <= tick;
            if (launch) begin
                len_q    <= pat_len;
                rep_q    <= rep_num;
                bit_idx  <= '0;
                pass_cnt <= '0;
            end else if (tick) begin
                if (bit_idx < len_q) begin
                    bit_idx <= bit_idx + LEN_W'(1);
                end else begin
                    bit_idx <= '0;
                    if (pass_cnt != '1) pass_cnt <= pass_cnt + REP_W'(1);
                end
            end
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Bench for seq_run_ctrl with a 4-cycle strobe period. A directed vector
// table, hand sequences for the multi-cycle corners, and random stimulus,
// all shadowed every cycle by a count-based reference model.
module tb_seq_run_ctrl;

    localparam int DIV_MAX = 3;
    localparam int PER     = DIV_MAX + 1;

    logic       sysclk = 1'b0;
    logic       rst    = 1'b0;
    logic       start  = 1'b0;
    logic       stop   = 1'b0;
    logic       pause  = 1'b0;
    logic [3:0] pat_len = '0;
    logic [7:0] rep_num = '0;
    logic       ld, sh_en, busy, done;
    logic [3:0] bit_idx;
    logic [7:0] pass_cnt;
    logic [2:0] state_o;

    always #5 sysclk = ~sysclk;

    seq_run_ctrl #(
        .DIV_W   (24),
        .DIV_MAX (DIV_MAX),
        .LEN_W   (4),
        .REP_W   (8)
    ) dut (
        .sysclk   (sysclk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .pat_len  (pat_len),
        .rep_num  (rep_num),
        .ld       (ld),
        .sh_en    (sh_en),
        .busy     (busy),
        .done     (done),
        .bit_idx  (bit_idx),
        .pass_cnt (pass_cnt),
        .state_o  (state_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode code, active (unpaused) run cycles and total
    // strobes since launch; bit index and pass count follow by arithmetic.
    int m_mode = 0, m_act = 0, m_strobes = 0, m_len = 0, m_rep = 0;
    bit e_ld = 0, e_sh = 0, e_done = 0;

    function automatic int m_bit();
        return m_strobes % (m_len + 1);
    endfunction

    function automatic int m_pass();
        int p;
        p = m_strobes / (m_len + 1);
        return (p > 255) ? 255 : p;
    endfunction

    function automatic logic [18:0] pk(input bit l, input bit s, input bit b, input bit d,
                                       input int bi, input int pa, input int st);
        return {l, s, b, d, 4'(bi), 8'(pa), 3'(st)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        e_ld = 0; e_sh = 0; e_done = 0;
        if (!rst) begin
            m_mode = 0; m_act = 0; m_strobes = 0; m_len = 0; m_rep = 0;
        end else begin
            case (m_mode)
                0: if (start && !stop) begin
                    m_mode = 1; e_ld = 1; m_len = pat_len; m_rep = rep_num;
                    m_act = 0; m_strobes = 0;
                end
                1: m_mode = stop ? 0 : (pause ? 3 : 2);
                2, 3: begin
                    if (stop) m_mode = 0;
                    else if (m_rep != 0 && m_pass() == m_rep) begin
                        m_mode = 4; e_done = 1;
                    end else begin
                        if (!pause) begin
                            m_act++;
                            if (m_act % PER == 0) begin
                                m_strobes++; e_sh = 1;
                            end
                        end
                        m_mode = pause ? 3 : 2;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic cycle();
        logic [18:0] a;
        @(posedge sysclk);
        model_edge();
        @(negedge sysclk);
        a = {ld, sh_en, busy, done, bit_idx, pass_cnt, state_o};
        chk("model", a, pk(e_ld, e_sh, (m_mode >= 1 && m_mode <= 3), e_done,
                           m_bit(), m_pass(), m_mode));
    endtask

    task automatic launch(input int len, input int rep);
        pat_len = 4'(len); rep_num = 8'(rep); start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_sh(input int budget, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!sh_en && n < budget);
        if (!sh_en) chk("wait_sh_timeout", 0, 1);
    endtask

    task automatic halt();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    typedef struct {
        logic        r, st, sp, pa;
        logic [3:0]  len;
        logic [7:0]  rep;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[15];

    initial begin
        int n, cnt, bad, last, gap, dones, lds, berr;
        bit seen;

        // reset held with start high, then a 2-bit single-pass run; config
        // changed mid-run must not matter
        tbl[0]  = '{0, 1, 0, 0, 4'd1, 8'd1, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{0, 1, 0, 0, 4'd1, 8'd1, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[2]  = '{0, 1, 0, 0, 4'd1, 8'd1, pk(0, 0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{1, 1, 0, 0, 4'd1, 8'd1, pk(1, 0, 1, 0, 0, 0, 1)};
        tbl[4]  = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 0, 1, 0, 0, 0, 2)};
        tbl[5]  = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 0, 1, 0, 0, 0, 2)};
        tbl[6]  = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 0, 1, 0, 0, 0, 2)};
        tbl[7]  = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 0, 1, 0, 0, 0, 2)};
        tbl[8]  = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 1, 1, 0, 1, 0, 2)};
        tbl[9]  = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 0, 1, 0, 1, 0, 2)};
        tbl[10] = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 0, 1, 0, 1, 0, 2)};
        tbl[11] = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 0, 1, 0, 1, 0, 2)};
        tbl[12] = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 1, 1, 0, 0, 1, 2)};
        tbl[13] = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 0, 0, 1, 0, 1, 4)};
        tbl[14] = '{1, 0, 0, 0, 4'd7, 8'd9, pk(0, 0, 0, 0, 0, 1, 0)};

        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].r; start = tbl[i].st; stop = tbl[i].sp; pause = tbl[i].pa;
            pat_len = tbl[i].len; rep_num = tbl[i].rep;
            cycle();
            chk($sformatf("vec%0d", i), {ld, sh_en, busy, done, bit_idx, pass_cnt, state_o},
                tbl[i].exp);
        end

        // 16 bits x 2 passes: 32 strobes every 4 cycles, done one cycle later
        launch(15, 2);
        chk("t2_ld", ld, 1);
        cnt = 0; bad = 0; last = -1; gap = -1; seen = 0; lds = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            cycle();
            if (ld) lds++;
            if (sh_en) begin
                if (last >= 0 && c - last != PER) bad++;
                last = c; cnt++;
            end
            if (done) begin
                seen = 1; gap = c - last;
                chk("t2_pass_at_done", pass_cnt, 2);
                chk("t2_busy_at_done", busy, 0);
            end
        end
        chk("t2_done_seen", seen, 1);
        chk("t2_sh_count", cnt, 32);
        chk("t2_bad_interval", bad, 0);
        chk("t2_done_gap", gap, 1);
        chk("t2_extra_ld", lds, 0);
        cycle();
        chk("t2_idle_after", state_o, 0);

        // pause for 10 cycles after the 5th strobe
        launch(15, 0);
        for (int k = 0; k < 5; k++) wait_sh(20, n);
        pause = 1'b1; cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (sh_en) cnt++;
            if (k == 0) chk("t3_paused_state", state_o, 3);
        end
        pause = 1'b0;
        wait_sh(40, n);
        chk("t3_sh_while_paused", cnt, 0);
        chk("t3_gap", 10 + n, 14);
        halt();
        chk("t3_stop_idle", state_o, 0);

        // repeat forever with 4-bit pattern, then stop
        launch(3, 0);
        cnt = 0; berr = 0; dones = 0;
        for (int c = 0; c < 1000 && cnt < 100; c++) begin
            cycle();
            if (done) dones++;
            if (sh_en) begin
                cnt++;
                if (bit_idx != 4'(cnt % 4)) berr++;
            end
        end
        chk("t4_strobes", cnt, 100);
        chk("t4_bit_seq_err", berr, 0);
        chk("t4_no_done", dones, 0);
        chk("t4_pass", pass_cnt, 25);
        halt();
        chk("t4_stop_state", state_o, 0);
        chk("t4_stop_busy", busy, 0);
        chk("t4_stop_done", done, 0);

        // stop + pause coincident with terminal count
        launch(15, 0);
        wait_sh(20, n);
        for (int k = 0; k < 3; k++) cycle();
        stop = 1'b1; pause = 1'b1;
        cycle();
        stop = 1'b0; pause = 1'b0;
        chk("t5_stop_sh", sh_en, 0);
        chk("t5_stop_state", state_o, 0);
        chk("t5_stop_done", done, 0);

        // pause alone at terminal count holds the strobe until release
        launch(15, 0);
        wait_sh(20, n);
        for (int k = 0; k < 3; k++) cycle();
        pause = 1'b1;
        cycle();
        chk("t5_pause_sh", sh_en, 0);
        chk("t5_pause_state", state_o, 3);
        pause = 1'b0;
        cycle();
        chk("t5_resume_sh", sh_en, 1);
        halt();

        // start held across DONE relaunches
        pat_len = 4'd0; rep_num = 8'd1; start = 1'b1;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            cycle();
            if (done) seen = 1;
        end
        chk("t6_done_seen", seen, 1);
        cycle();
        chk("t6_idle", state_o, 0);
        cycle();
        chk("t6_load_state", state_o, 1);
        chk("t6_ld", ld, 1);
        chk("t6_pass", pass_cnt, 0);
        start = 1'b0;
        halt();

        // pass counter saturates with rep_num=0
        launch(0, 0);
        dones = 0;
        for (int c = 0; c < 260 * PER; c++) begin
            cycle();
            if (done) dones++;
        end
        chk("sat_pass", pass_cnt, 255);
        chk("sat_no_done", dones, 0);
        halt();

        // random stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 299) != 0);
            start   = ($urandom_range(0, 9) == 0);
            stop    = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 15) == 0) pause = ~pause;
            pat_len = 4'($urandom_range(0, 3));
            rep_num = 8'($urandom_range(0, 3));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
